i2c_start_arbiter: RTL and testbench

Multi-channel launch controller for the I2C master core. Detects rising edges on NCH independent `start` requests, queues one pending request per channel, grants channels round-robin and drives a single `enable` level into the core until the core acknowledges with `busy`. Reports per-channel completion, launch timeout and request overrun as one-cycle pulses. Sits between the register/bus front-ends and the shared I2C byte engine.

---
 rtl/i2c_arb_pkg.sv | 27 ++
 rtl/i2c_rr_pick.sv | 45 ++++
 rtl/i2c_start_arbiter.sv | 154 +++++++++++++++
 tb/tb_i2c_start_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared constants for the I2C start arbiter: FSM state
//               encoding, default launch timeout and a counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // Launch timeout used when the instantiating block does not override it
  localparam int DEFAULT_TIMEOUT = 1024;

  // Bits needed to count 0..n-1, never less than one bit so a disabled
  // timeout still yields a legal vector width.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_rr_pick.sv
// ============================================================================
// Module      : i2c_rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of the pending vector at or above the pointer, wrapping to
//               the lowest set bit below it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_rr_pick #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] pending,
  input  logic [CW-1:0]  ptr,
  output logic           valid,
  output logic [NCH-1:0] onehot,
  output logic [CW-1:0]  index
);

  // Two passes: upper region from the pointer first, then a wrap scan that
  // only matters when nothing at or above the pointer is pending.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    index  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!valid && pending[i] && (CW'(i) >= ptr)) begin
        valid     = 1'b1;
        onehot[i] = 1'b1;
        index     = CW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!valid && pending[i]) begin
        valid     = 1'b1;
        onehot[i] = 1'b1;
        index     = CW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_start_arbiter.sv
// ============================================================================
// Module      : i2c_start_arbiter
// Description : Multi-channel launch controller for the I2C master core.
//               Edge-detects per-channel start requests, keeps one pending
//               request per channel, grants round-robin and holds enable
//               until the core reports busy. Reports done/timeout/overrun
//               as single-cycle pulses. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_start_arbiter
  import i2c_arb_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int CW      = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] start,
  input  logic           busy,
  output logic           enable,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  chan_id,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] tmo,
  output logic [NCH-1:0] ovr
);

  localparam int             CTW        = cnt_width(TIMEOUT + 1);
  localparam bit             C_TMO_EN   = (TIMEOUT != 0);
  localparam logic [CTW-1:0] C_TMO_LAST = (TIMEOUT == 0) ? '0 : CTW'(TIMEOUT - 1);
  localparam logic [CTW-1:0] C_CNT_MAX  = '1;
  localparam logic [CW-1:0]  C_LAST_CH  = CW'(NCH - 1);

  logic [NCH-1:0] r_prev_start;
  logic [NCH-1:0] r_pending;
  logic [CW-1:0]  r_ptr;
  logic [1:0]     r_state;
  logic [CTW-1:0] r_cnt;
  logic           r_enable;
  logic [NCH-1:0] r_grant;
  logic [CW-1:0]  r_chan_id;
  logic [NCH-1:0] r_done;
  logic [NCH-1:0] r_tmo;
  logic [NCH-1:0] r_ovr;

  logic [NCH-1:0] w_edge;
  logic           w_valid;
  logic [NCH-1:0] w_onehot;
  logic [CW-1:0]  w_index;
  logic           w_take;
  logic [NCH-1:0] w_clr;
  logic [CW-1:0]  w_ptr_next;

  assign w_edge     = start & ~r_prev_start;
  // A grant happens only from IDLE while the core is quiet
  assign w_take     = (r_state == ST_IDLE) && w_valid && !busy;
  assign w_clr      = w_take ? w_onehot : '0;
  assign w_ptr_next = (w_index == C_LAST_CH) ? '0 : (w_index + 1'b1);

  i2c_rr_pick #(
    .NCH (NCH)
  ) u_pick (
    .pending (r_pending),
    .ptr     (r_ptr),
    .valid   (w_valid),
    .onehot  (w_onehot),
    .index   (w_index)
  );

  // Edge detection, pending set/clear and overrun pulses; an edge in the
  // same cycle as the grant-clear re-arms the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_start <= '1;
      r_pending    <= '0;
      r_ovr        <= '0;
    end else begin
      r_prev_start <= start;
      r_pending    <= (r_pending & ~w_clr) | w_edge;
      r_ovr        <= w_edge & r_pending & ~w_clr;
    end
  end

  // Launch FSM: grant, enable until busy (or timeout), hold grant until
  // busy falls; done/tmo are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_enable  <= 1'b0;
      r_grant   <= '0;
      r_chan_id <= '0;
      r_done    <= '0;
      r_tmo     <= '0;
      r_ptr     <= '0;
    end else begin
      r_done <= '0;
      r_tmo  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state   <= ST_LAUNCH;
            r_enable  <= 1'b1;
            r_grant   <= w_onehot;
            r_chan_id <= w_index;
            r_cnt     <= '0;
            r_ptr     <= w_ptr_next;
          end
        end
        ST_LAUNCH: begin
          if (busy) begin
            r_state  <= ST_RUN;
            r_enable <= 1'b0;
          end else if (C_TMO_EN && (r_cnt == C_TMO_LAST)) begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_tmo     <= r_grant;
            r_grant   <= '0;
            r_chan_id <= '0;
          end else if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!busy) begin
            r_state   <= ST_IDLE;
            r_done    <= r_grant;
            r_grant   <= '0;
            r_chan_id <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_enable  <= 1'b0;
          r_grant   <= '0;
          r_chan_id <= '0;
        end
      endcase
    end
  end

  assign enable  = r_enable;
  assign grant   = r_grant;
  assign chan_id = r_chan_id;
  assign done    = r_done;
  assign tmo     = r_tmo;
  assign ovr     = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_start_arbiter.sv
// ============================================================================
// Module      : tb_i2c_start_arbiter
// Description : Self-checking bench for i2c_start_arbiter (NCH=4,
//               TIMEOUT=8). A channel/transfer-level reference model predicts
//               every registered output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_start_arbiter;

  localparam int NCH = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start;
  logic       busy;
  logic       enable;
  logic [3:0] grant;
  logic [1:0] chan_id;
  logic [3:0] done;
  logic [3:0] tmo;
  logic [3:0] ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_start_arbiter #(
    .NCH     (NCH),
    .TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .enable  (enable),
    .grant   (grant),
    .chan_id (chan_id),
    .done    (done),
    .tmo     (tmo),
    .ovr     (ovr)
  );

  // Reference model: which channel owns the core, whether the core has
  // picked it up, and how long the launch has been waiting.
  bit         m_pend [NCH];
  bit         m_prev [NCH];
  int         m_ptr;
  int         m_act;
  bit         m_run;
  int         m_age;
  logic       m_enable;
  logic [3:0] m_grant, m_done, m_tmo, m_ovr;
  logic [1:0] m_chan;

  // Core emulation driving busy
  int   core_mode;    // 0 auto, 1 never busy, 2 forced level
  logic force_busy;
  bit   rnd;
  int   lat, hold, wait_left, hold_left;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b1;
    end
    m_ptr = 0; m_act = -1; m_run = 1'b0; m_age = 0;
    m_enable = 1'b0; m_grant = '0; m_chan = '0;
    m_done = '0; m_tmo = '0; m_ovr = '0;
  endtask

  task automatic model_edge();
    int taken;
    if (reset) begin
      model_reset();
      return;
    end
    taken = -1;
    m_done = '0; m_tmo = '0; m_ovr = '0;
    if (m_act < 0) begin
      if (!busy) begin
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_ptr + k) % NCH;
          if (taken < 0 && m_pend[c]) taken = c;
        end
      end
      if (taken >= 0) begin
        m_act = taken; m_run = 1'b0; m_age = 0; m_enable = 1'b1;
        m_ptr = (taken + 1) % NCH;
      end
    end else if (!m_run) begin
      if (busy) begin
        m_run = 1'b1; m_enable = 1'b0;
      end else if (TMO != 0 && m_age == TMO - 1) begin
        m_tmo = 4'(1) << m_act; m_act = -1; m_enable = 1'b0;
      end else begin
        m_age++;
      end
    end else if (!busy) begin
      m_done = 4'(1) << m_act; m_act = -1;
    end
    for (int i = 0; i < NCH; i++) begin
      bit e;
      e = start[i] && !m_prev[i];
      if (i == taken) m_pend[i] = 1'b0;
      if (e) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
      m_prev[i] = start[i];
    end
    m_grant = (m_act >= 0) ? (4'(1) << m_act) : 4'd0;
    m_chan  = (m_act >= 0) ? 2'(m_act) : 2'd0;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("enable",  {3'b000, enable},  {3'b000, m_enable});
    check("grant",   grant,             m_grant);
    check("chan_id", {2'b00, chan_id},  {2'b00, m_chan});
    check("done",    done,              m_done);
    check("tmo",     tmo,               m_tmo);
    check("ovr",     ovr,               m_ovr);
  endtask

  task automatic drive_busy();
    case (core_mode)
      0: begin
        if (busy) begin
          if (hold_left == 0) busy = 1'b0;
          else hold_left--;
        end else if (m_enable) begin
          if (wait_left == 0) begin
            busy = 1'b1;
            hold_left = rnd ? int'($urandom_range(0, 5)) : hold;
          end else begin
            wait_left--;
          end
        end else begin
          wait_left = rnd ? int'($urandom_range(0, 9)) : lat;
        end
      end
      1:       busy = 1'b0;
      default: busy = force_busy;
    endcase
  endtask

  // One clock: apply start, let the core react, advance the model, compare
  task automatic cyc(input logic [3:0] st);
    start = st;
    drive_busy();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] st;
    reset = 1'b1; start = 4'hF; busy = 1'b0;
    core_mode = 2; force_busy = 1'b0; rnd = 1'b0;
    lat = 2; hold = 3; wait_left = 0; hold_left = 0;
    model_reset();
    #2;
    compare_all();
    cyc(4'hF); cyc(4'hF);
    reset = 1'b0;

    // All starts held high through reset release: no request until ch3 re-rises
    core_mode = 0; lat = 2; hold = 3;
    repeat (5) cyc(4'hF);
    cyc(4'h7); cyc(4'h7);
    repeat (14) cyc(4'hF);
    repeat (2) cyc(4'h0);

    // Simultaneous edges on ch0, ch1, ch3 with pointer at 0
    cyc(4'b1011);
    repeat (40) cyc(4'b1011);
    repeat (2) cyc(4'h0);

    // Single ch2 request: busy three cycles after enable, held ten cycles
    lat = 2; hold = 9;
    cyc(4'b0100);
    repeat (20) cyc(4'b0100);
    cyc(4'h0);

    // Launch timeout on ch1
    core_mode = 1; busy = 1'b0;
    cyc(4'b0010);
    repeat (12) cyc(4'b0010);
    cyc(4'h0);

    // Re-arm during RUN, then overrun before regrant
    core_mode = 2; force_busy = 1'b0;
    cyc(4'h1); cyc(4'h1);
    force_busy = 1'b1;
    cyc(4'h1); cyc(4'h0); cyc(4'h1); cyc(4'h0); cyc(4'h1);
    repeat (2) cyc(4'h1);
    force_busy = 1'b0;
    repeat (2) cyc(4'h1);
    force_busy = 1'b1;
    repeat (2) cyc(4'h1);
    force_busy = 1'b0;
    repeat (3) cyc(4'h0);

    // Asynchronous reset while RUN with another request pending
    cyc(4'b0100); cyc(4'b0100);
    force_busy = 1'b1;
    cyc(4'b0100); cyc(4'b0101); cyc(4'b0101);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    cyc(4'h0); cyc(4'h0);
    reset = 1'b0;
    cyc(4'h0);
    cyc(4'h1);
    repeat (4) cyc(4'h1);
    force_busy = 1'b0;
    repeat (2) cyc(4'h1);
    force_busy = 1'b1;
    repeat (2) cyc(4'h1);
    force_busy = 1'b0;
    repeat (3) cyc(4'h0);

    // Randomized traffic with random core latency (some beyond the timeout)
    core_mode = 0; rnd = 1'b1; busy = 1'b0; hold_left = 0;
    st = 4'h0;
    repeat (600) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 3) == 0) st[i] = ~st[i];
      cyc(st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
